// File: rtl/picoblaze_io_pkg.sv
// rtl/picoblaze_io_pkg.sv - shared hub register map, irq FSM encoding and priority helper
package picoblaze_io_pkg;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_VECTOR  = 2'd2;
    localparam logic [1:0] REG_RAW     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    // Index of the lowest set bit; 0 when nothing is set (callers gate on |v).
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/io_irq_ctrl.sv
// rtl/io_irq_ctrl.sv - edge-detected, maskable, prioritised interrupt controller with ack/EOI
module io_irq_ctrl
    import picoblaze_io_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] ch_irq,
    input  logic            mask_we,
    input  logic [N_CH-1:0] mask_wdata,
    input  logic [N_CH-1:0] w1c,
    input  logic            eoi,
    input  logic            interrupt_ack,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] mask,
    output logic [2:0]      vector,
    output logic            active,
    output logic            interrupt,
    output irq_state_t      state
);

    logic [N_CH-1:0] irq_q;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] ack_clr;
    logic [N_CH-1:0] req;

    // Rising edges, the ack-time clear of the serviced bit, and enabled requests
    always_comb begin
        rise    = ch_irq & ~irq_q;
        ack_clr = '0;
        if (state == ST_REQ && interrupt_ack) ack_clr = N_CH'(1) << vector;
        req     = pending & mask;
    end

    // Edge history, pending (new edges beat both clears) and mask registers
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= ch_irq;
            pending <= '0;
            mask    <= '0;
        end else begin
            irq_q   <= ch_irq;
            pending <= (pending & ~w1c & ~ack_clr) | rise;
            if (mask_we) mask <= mask_wdata;
        end
    end

    // Request/acknowledge/EOI sequencer; vector is frozen from IDLE until the next arbitration
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            interrupt <= 1'b0;
            vector    <= 3'd0;
            active    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        vector    <= lowest_set(8'(req));
                        interrupt <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (interrupt_ack) begin
                        interrupt <= 1'b0;
                        active    <= 1'b1;
                        state     <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (eoi) begin
                        active <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    interrupt <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/picoblaze_io_hub.sv
// rtl/picoblaze_io_hub.sv - KCPSM6 port-ID decode, registered read mux and hub registers
module picoblaze_io_hub
    import picoblaze_io_pkg::*;
#(
    parameter int                 N_CH      = 4,
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 8,
    parameter int                 SPAN_LOG2 = 4,
    parameter logic [ADDR_W-1:0]  HUB_BASE  = 8'hF0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      port_id,
    input  logic [DATA_W-1:0]      out_port,
    input  logic                   write_strobe,
    input  logic                   read_strobe,
    output logic [DATA_W-1:0]      in_port,
    output logic                   interrupt,
    input  logic                   interrupt_ack,
    output logic [N_CH-1:0]        ch_sel,
    output logic [SPAN_LOG2-1:0]   ch_addr,
    output logic [N_CH-1:0]        ch_write,
    output logic [N_CH-1:0]        ch_read,
    input  logic [N_CH*DATA_W-1:0] ch_rdata,
    input  logic [N_CH-1:0]        ch_irq
);

    localparam int SEL_W = ADDR_W - SPAN_LOG2;

    logic [ADDR_W-1:0] hub_rel;
    logic              hub_hit;
    logic [1:0]        hub_off;
    logic              hub_we;
    logic [DATA_W-1:0] rd_mux;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   mask;
    logic [2:0]        vector;
    logic              active;
    irq_state_t        irq_state;
    logic              unused_bits;

    assign unused_bits = ^{out_port, irq_state};

    // Channel window decode and the small hub register window above the channels
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_sel[i] = (port_id[ADDR_W-1:SPAN_LOG2] == SEL_W'(i));
        end
        ch_addr  = port_id[SPAN_LOG2-1:0];
        ch_write = ch_sel & {N_CH{write_strobe}};
        ch_read  = ch_sel & {N_CH{read_strobe}};
        hub_rel  = port_id - HUB_BASE;
        hub_hit  = (port_id >= HUB_BASE) && (hub_rel < ADDR_W'(4));
        hub_off  = hub_rel[1:0];
        hub_we   = hub_hit && write_strobe;
    end

    // Read-data selection; unmapped addresses return zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel[i]) rd_mux = ch_rdata[i*DATA_W +: DATA_W];
        end
        if (hub_hit) begin
            case (hub_off)
                REG_PENDING: rd_mux = DATA_W'(pending);
                REG_MASK:    rd_mux = DATA_W'(mask);
                REG_VECTOR: begin
                    rd_mux[7]   = active;
                    rd_mux[2:0] = vector;
                end
                default:     rd_mux = DATA_W'(ch_irq);
            endcase
        end
    end

    // Read data is registered every cycle so it is ready for the INPUT instruction
    always_ff @(posedge clk) begin
        if (reset) in_port <= '0;
        else       in_port <= rd_mux;
    end

    io_irq_ctrl #(.N_CH(N_CH)) u_irq (
        .clk           (clk),
        .reset         (reset),
        .ch_irq        (ch_irq),
        .mask_we       (hub_we && hub_off == REG_MASK),
        .mask_wdata    (out_port[N_CH-1:0]),
        .w1c           ((hub_we && hub_off == REG_PENDING) ? out_port[N_CH-1:0] : '0),
        .eoi           (hub_we && hub_off == REG_VECTOR),
        .interrupt_ack (interrupt_ack),
        .pending       (pending),
        .mask          (mask),
        .vector        (vector),
        .active        (active),
        .interrupt     (interrupt),
        .state         (irq_state)
    );

endmodule

// File: tb/tb_picoblaze_io_hub.sv
// tb/tb_picoblaze_io_hub.sv - directed scoreboard bench for picoblaze_io_hub
module tb_picoblaze_io_hub;
    import picoblaze_io_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  port_id = 8'h00;
    logic [7:0]  out_port = 8'h00;
    logic        write_strobe = 1'b0;
    logic        read_strobe = 1'b0;
    logic [7:0]  in_port;
    logic        interrupt;
    logic        interrupt_ack = 1'b0;
    logic [3:0]  ch_sel;
    logic [3:0]  ch_addr;
    logic [3:0]  ch_write;
    logic [3:0]  ch_read;
    logic [31:0] ch_rdata = 32'h0;
    logic [3:0]  ch_irq = 4'h0;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    picoblaze_io_hub dut (
        .clk           (clk),
        .reset         (reset),
        .port_id       (port_id),
        .out_port      (out_port),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .ch_sel        (ch_sel),
        .ch_addr       (ch_addr),
        .ch_write      (ch_write),
        .ch_read       (ch_read),
        .ch_rdata      (ch_rdata),
        .ch_irq        (ch_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] p, input logic [7:0] e, input string tag);
        port_id     = p;
        read_strobe = 1'b1;
        exp_q.push_back(32'(e));
        tag_q.push_back(tag);
        tick();
        read_strobe = 1'b0;
        check(tag_q.pop_front(), 32'(in_port), exp_q.pop_front());
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        port_id      = p;
        out_port     = d;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] v);
        ch_irq = ch_irq | v;
        tick();
        ch_irq = ch_irq & ~v;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    task automatic wait_irq(input int max, input string tag);
        int n;
        n = 0;
        while (interrupt !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(interrupt), 32'd1);
    endtask

    initial begin
        ch_irq = 4'b1000;
        repeat (3) tick();
        check("rst_in_port", 32'(in_port), 32'h0);
        check("rst_interrupt", 32'(interrupt), 32'h0);
        reset = 1'b0;
        tick();
        rd(8'hF0, 8'h00, "rst_pending_held_line");
        rd(8'hF1, 8'h00, "rst_mask");
        rd(8'hF2, 8'h00, "rst_vector");
        rd(8'hF3, 8'h08, "raw_levels");
        ch_irq = 4'b0000;
        tick();

        ch_rdata = 32'h44_33_A5_11;
        port_id = 8'h12;
        #1;
        check("sel_0x12", 32'(ch_sel), 32'b0010);
        check("addr_0x12", 32'(ch_addr), 32'd2);
        rd(8'h12, 8'hA5, "rd_0x12");
        rd(8'h3F, 8'h44, "rd_0x3F");

        port_id = 8'h35;
        out_port = 8'h37;
        write_strobe = 1'b1;
        #1;
        check("wr_0x35", 32'(ch_write), 32'b1000);
        check("rd_0x35_idle", 32'(ch_read), 32'b0000);
        tick();
        write_strobe = 1'b0;
        rd(8'h77, 8'h00, "rd_unmapped_0x77");
        port_id = 8'h40;
        #1;
        check("sel_0x40", 32'(ch_sel), 32'b0000);

        wr(8'hF1, 8'h0F);
        rd(8'hF1, 8'h0F, "mask_readback");
        pulse(4'b0110);
        wait_irq(5, "irq_ch1_ch2");
        rd(8'hF2, 8'h01, "vector_ch1");
        ack();
        check("irq_drop_on_ack", 32'(interrupt), 32'h0);
        rd(8'hF0, 8'h04, "pending_after_ack");
        rd(8'hF2, 8'h81, "vector_active_ch1");
        wr(8'hF2, 8'h00);
        wait_irq(5, "irq_ch2_after_eoi");
        rd(8'hF2, 8'h02, "vector_ch2");
        ack();
        wr(8'hF2, 8'h00);
        rd(8'hF0, 8'h00, "pending_empty");

        wr(8'hF1, 8'h00);
        pulse(4'b0001);
        tick();
        rd(8'hF0, 8'h01, "pending_masked");
        check("irq_masked_quiet", 32'(interrupt), 32'h0);
        wr(8'hF1, 8'h01);
        check("irq_not_yet_after_mask", 32'(interrupt), 32'h0);
        tick();
        check("irq_two_cycles_after_mask", 32'(interrupt), 32'h1);
        ack();
        wr(8'hF2, 8'h00);
        wr(8'hF1, 8'h00);

        pulse(4'b0001);
        rd(8'hF0, 8'h01, "pending_pre_collision");
        port_id = 8'hF0;
        out_port = 8'h01;
        write_strobe = 1'b1;
        ch_irq = 4'b0001;
        tick();
        write_strobe = 1'b0;
        rd(8'hF0, 8'h01, "edge_beats_w1c");
        wr(8'hF0, 8'h01);
        rd(8'hF0, 8'h00, "w1c_clears");
        ch_irq = 4'b0000;
        tick();

        wr(8'hF1, 8'h01);
        pulse(4'b0001);
        wait_irq(5, "irq_before_reset");
        reset = 1'b1;
        tick();
        check("irq_after_reset", 32'(interrupt), 32'h0);
        check("state_after_reset", 32'(dut.u_irq.state), 32'(ST_IDLE));
        reset = 1'b0;
        ack();
        tick();
        check("late_ack_ignored", 32'(interrupt), 32'h0);
        rd(8'hF2, 8'h00, "vector_after_reset");
        rd(8'hF0, 8'h00, "pending_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/picoblaze_io_hub.md
Name: picoblaze_io_hub

Overview:
- Parametrised port-ID interconnect between the KCPSM6 micro and N_CH peripheral channels (RTC, keyboard, VGA, audio, future units).
- Replaces hand-wired act*/in_port muxing with:
  - windowed address decode,
  - registered read-data mux,
  - per-channel strobes,
  - a prioritised, maskable interrupt controller with a KCPSM6 ack handshake and software end-of-interrupt (EOI).
- Sits directly between the micro wrapper and all peripherals at the top level.

Parameters:
- N_CH, 4: number of peripheral channels (1..8).
- DATA_W, 8: data width of out_port/in_port.
- ADDR_W, 8: port_id width.
- SPAN_LOG2, 4: log2 of the ports owned per channel. Channel i owns ports i*2^SPAN_LOG2 .. (i+1)*2^SPAN_LOG2-1.
- HUB_BASE, 8'hF0: base port of the hub registers. Constraint: N_CH*2^SPAN_LOG2 <= HUB_BASE.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- port_id  in  ADDR_W  KCPSM6 port address.
- out_port  in  DATA_W  KCPSM6 write data.
- write_strobe  in  1  KCPSM6 write strobe.
- read_strobe  in  1  KCPSM6 read strobe.
- in_port  out  DATA_W  registered read data to KCPSM6.
- interrupt  out  1  interrupt request to KCPSM6.
- interrupt_ack  in  1  KCPSM6 interrupt acknowledge.
- ch_sel  out  N_CH  one-hot channel select (combinational decode of port_id).
- ch_addr  out  SPAN_LOG2  local offset, equal to port_id[SPAN_LOG2-1:0].
- ch_write  out  N_CH  ch_sel & write_strobe.
- ch_read  out  N_CH  ch_sel & read_strobe.
- ch_rdata  in  N_CH*DATA_W  channel read data; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_irq  in  N_CH  channel interrupt lines. Only rising edges are significant.

Behaviour:
- Decode:
  - ch_sel[i]=1 iff port_id[ADDR_W-1:SPAN_LOG2]==i and i<N_CH.
  - Hub window is HUB_BASE..HUB_BASE+3.
  - Any other address: no select, read data 0, writes ignored.
- Read path:
  - in_port <= mux(port_id) every cycle, regardless of read_strobe. One cycle latency, which meets the KCPSM6 INPUT timing.
- Hub registers:
  - HUB_BASE+0 PENDING: read = pending[N_CH-1:0], zero-extended. Write is write-1-to-clear per bit.
  - HUB_BASE+1 MASK: read/write. 1 = channel enabled.
  - HUB_BASE+2 VECTOR: read = {active flag in bit 7, channel index in low 3 bits}. Any write = EOI.
  - HUB_BASE+3 RAW: read = current ch_irq levels. Writes ignored.
- Edge detect:
  - irq_q <= ch_irq each cycle.
  - pending[i] sets when ch_irq[i] & ~irq_q[i].
  - During reset irq_q <= ch_irq, so lines already high at reset release do not fire.
- Interrupt FSM, states IDLE, REQ, SERVICE:
  - IDLE: if |(pending & mask), latch vector = lowest set index of (pending & mask), interrupt<=1 next cycle, go REQ.
  - REQ: interrupt held at 1 until interrupt_ack==1. On that cycle: interrupt<=0, pending[vector]<=0, active<=1, go SERVICE.
    - Clearing the mask or the pending bit while in REQ does not retract the request or change vector.
  - SERVICE: interrupt stays 0. A write to VECTOR: active<=0, go IDLE; re-arbitration happens on the next cycle.
  - interrupt_ack outside REQ is ignored.
- Priority: lowest channel index wins. Channels remain pending while another channel is serviced.
- Simultaneous events on the same pending bit in the same cycle: a new edge wins over a W1C clear and over an ack clear, so the bit stays set.
- Reset values: in_port=0, interrupt=0, pending=0, mask=0, vector=0, active=0, state=IDLE.
  - Reset mid-REQ or mid-SERVICE drops interrupt on the next edge and forgets any in-flight vector.

Decomposition:
- Package picoblaze_io_pkg holds:
  - hub register offsets (PENDING=0, MASK=1, VECTOR=2, RAW=3),
  - FSM state encoding,
  - a lowest-set-bit priority function.
- One natural sub-module: io_irq_ctrl, containing edge detect, pending/mask registers, FSM and vector. The top module keeps decode and the read mux.

Test Plan:
- Reset, then read port 0x12 with ch_rdata[15:8]=8'hA5 -> ch_sel=4'b0010, ch_addr=2; in_port=8'hA5 one cycle after port_id is applied.
- Write 0x37 to port 0x35 with write_strobe -> ch_write=4'b1000 in the same cycle. Read port 0x77 (unmapped) -> in_port=0.
- MASK=0x0F; pulse ch_irq[2] and ch_irq[1] in the same cycle -> interrupt=1, vector=1. Ack -> pending=0x04. Write VECTOR (EOI) -> interrupt reasserts with vector=2.
- MASK=0; pulse ch_irq[0] -> PENDING reads 0x01 and interrupt stays 0. Then set MASK=0x01 -> interrupt=1 on the second cycle after the write.
- Hold ch_irq[3]=1 through reset release -> no pending bit. Edge on ch_irq[0] in the same cycle as a W1C write of 0x01 -> PENDING bit 0 stays 1.
- Assert reset while in REQ -> interrupt=0 and state IDLE on the next edge; a later interrupt_ack has no effect.
